// File: rtl/dpi_prot_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dpi_prot_chk_pkg
// Brief   : Shared types and widths for the protected-DPI output checker.
// Revision: 1.0
// ============================================================================
package dpi_prot_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    FLD_ACCUM = 3'd0,
    FLD_S1    = 3'd1,
    FLD_S2    = 3'd2,
    FLD_S8    = 3'd3,
    FLD_S33   = 3'd4,
    FLD_S64   = 3'd5,
    FLD_S65   = 3'd6,
    FLD_S129  = 3'd7
  } field_e;

  localparam int W_ACCUM = 32;
  localparam int W_S1    = 1;
  localparam int W_S2    = 2;
  localparam int W_S8    = 8;
  localparam int W_S33   = 33;
  localparam int W_S64   = 64;
  localparam int W_S65   = 65;
  localparam int W_S129  = 129;
  localparam int W_PASS  = W_S1 + W_S2 + W_S8 + W_S33 + W_S64 + W_S65 + W_S129;
  localparam int W_STIM  = W_PASS + W_ACCUM;

  typedef struct packed {
    logic [W_ACCUM-1:0] accum;
    logic [W_S1-1:0]    s1;
    logic [W_S2-1:0]    s2;
    logic [W_S8-1:0]    s8;
    logic [W_S33-1:0]   s33;
    logic [W_S64-1:0]   s64;
    logic [W_S65-1:0]   s65;
    logic [W_S129-1:0]  s129;
  } stim_t;

  // Bit i of fail corresponds to field code i; the lowest set code wins.
  function automatic field_e lowest_field(input logic [7:0] fail);
    field_e f;
    f = FLD_ACCUM;
    for (int i = 7; i >= 0; i--) begin
      if (fail[i]) f = field_e'(i[2:0]);
    end
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dpi_prot_chk_delay.sv
`default_nettype none
// ============================================================================
// Module  : dpi_prot_chk_delay
// Brief   : DEPTH-stage shift register with a valid bit travelling per stage.
// Revision: 1.0
// ============================================================================
module dpi_prot_chk_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
      r_valid <= '0;
    end else begin
      r_data[0]  <= in_data;
      r_valid[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dpi_prot_checker.sv
`default_nettype none
// ============================================================================
// Module  : dpi_prot_checker
// Brief   : Delays sampled stimulus through a reference model and scores the
//           secret block's outputs, reporting count, first failure and verdict.
// Revision: 1.0
// ============================================================================
module dpi_prot_checker
  import dpi_prot_chk_pkg::*;
#(
  parameter int LATENCY      = 1,
  parameter int CHECK_CYCLES = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [W_ACCUM-1:0] accum_in,
  input  logic [W_ACCUM-1:0] accum_out,
  input  logic [W_S1-1:0]    s1_in,
  input  logic [W_S1-1:0]    s1_out,
  input  logic [W_S2-1:0]    s2_in,
  input  logic [W_S2-1:0]    s2_out,
  input  logic [W_S8-1:0]    s8_in,
  input  logic [W_S8-1:0]    s8_out,
  input  logic [W_S33-1:0]   s33_in,
  input  logic [W_S33-1:0]   s33_out,
  input  logic [W_S64-1:0]   s64_in,
  input  logic [W_S64-1:0]   s64_out,
  input  logic [W_S65-1:0]   s65_in,
  input  logic [W_S65-1:0]   s65_out,
  input  logic [W_S129-1:0]  s129_in,
  input  logic [W_S129-1:0]  s129_out,
  output logic [15:0]        mismatch_cnt,
  output logic [15:0]        first_err_idx,
  output logic [2:0]         first_err_field,
  output logic               done,
  output logic               pass
);

  state_e       r_state, w_state_nxt;
  stim_t        w_stim_in, w_tail;
  logic         w_tail_valid;
  logic         w_push, w_compare, w_last;
  logic [1:0]   r_fill_cnt;
  logic [15:0]  r_cmp_idx;
  logic [31:0]  r_acc_sum, w_acc_exp;
  logic [7:0]   w_fail;
  logic [15:0]  r_mismatch_cnt, r_first_idx;
  field_e       r_first_field;
  logic         r_done;

  assign w_stim_in = {accum_in, s1_in, s2_in, s8_in, s33_in, s64_in, s65_in, s129_in};

  // Sampling begins on the start edge and stops once the run has finished.
  assign w_push = (r_state == ST_IDLE && en) || (r_state == ST_FILL) || (r_state == ST_CHECK);

  dpi_prot_chk_delay #(
    .DEPTH (LATENCY),
    .WIDTH (W_STIM)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_push),
    .in_data   (w_stim_in),
    .out_valid (w_tail_valid),
    .out_data  (w_tail)
  );

  assign w_compare = (r_state == ST_CHECK) && w_tail_valid;
  assign w_last    = (r_cmp_idx == 16'(CHECK_CYCLES - 1));
  assign w_acc_exp = r_acc_sum + w_tail.accum;

  assign w_fail[0] = (accum_out != w_acc_exp);
  assign w_fail[1] = (s1_out    != w_tail.s1);
  assign w_fail[2] = (s2_out    != w_tail.s2);
  assign w_fail[3] = (s8_out    != w_tail.s8);
  assign w_fail[4] = (s33_out   != w_tail.s33);
  assign w_fail[5] = (s64_out   != w_tail.s64);
  assign w_fail[6] = (s65_out   != w_tail.s65);
  assign w_fail[7] = (s129_out  != w_tail.s129);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (en) w_state_nxt = (LATENCY == 1) ? ST_CHECK : ST_FILL;
      ST_FILL:  if (r_fill_cnt == 2'(LATENCY - 2)) w_state_nxt = ST_CHECK;
      ST_CHECK: if (w_compare && w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_cnt     <= '0;
      r_cmp_idx      <= '0;
      r_acc_sum      <= '0;
      r_mismatch_cnt <= '0;
      r_first_idx    <= '0;
      r_first_field  <= FLD_ACCUM;
      r_done         <= 1'b0;
    end else begin
      if (r_state == ST_FILL) r_fill_cnt <= r_fill_cnt + 2'd1;
      // done lags the final comparison by one edge.
      if (r_state == ST_DONE) r_done <= 1'b1;
      if (w_compare) begin
        r_acc_sum <= w_acc_exp;
        r_cmp_idx <= r_cmp_idx + 16'd1;
        if (|w_fail) begin
          if (r_mismatch_cnt != 16'hFFFF) r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
          if (r_mismatch_cnt == 16'd0) begin
            r_first_idx   <= r_cmp_idx;
            r_first_field <= lowest_field(w_fail);
          end
        end
      end
    end
  end

  assign mismatch_cnt    = r_mismatch_cnt;
  assign first_err_idx   = r_first_idx;
  assign first_err_field = r_first_field;
  assign done            = r_done;
  assign pass            = r_done && (r_mismatch_cnt == 16'd0);

endmodule
`default_nettype wire

// File: tb/tb_dpi_prot_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_dpi_prot_checker
// Brief   : Drives a behavioural secret-block stub into LATENCY=1 and
//           LATENCY=3 checkers and scores their verdicts against a queue.
// Revision: 1.0
// ============================================================================
module tb_dpi_prot_checker;

  localparam int C_CYCLES = 10;

  logic clk = 1'b0;
  logic rst, en1, en3;
  logic [31:0]  accum_in, accum_out;
  logic         s1_in, s1_out;
  logic [1:0]   s2_in, s2_out;
  logic [7:0]   s8_in, s8_out;
  logic [32:0]  s33_in, s33_out;
  logic [63:0]  s64_in, s64_out;
  logic [64:0]  s65_in, s65_out;
  logic [128:0] s129_in, s129_out;

  logic [15:0] mc1, fi1, mc3, fi3;
  logic [2:0]  ff1, ff3;
  logic        d1, p1, d3, p3;

  always #5 clk = ~clk;

  dpi_prot_checker #(.LATENCY(1), .CHECK_CYCLES(C_CYCLES)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1),
    .accum_in(accum_in), .accum_out(accum_out), .s1_in(s1_in), .s1_out(s1_out),
    .s2_in(s2_in), .s2_out(s2_out), .s8_in(s8_in), .s8_out(s8_out),
    .s33_in(s33_in), .s33_out(s33_out), .s64_in(s64_in), .s64_out(s64_out),
    .s65_in(s65_in), .s65_out(s65_out), .s129_in(s129_in), .s129_out(s129_out),
    .mismatch_cnt(mc1), .first_err_idx(fi1), .first_err_field(ff1), .done(d1), .pass(p1)
  );

  dpi_prot_checker #(.LATENCY(3), .CHECK_CYCLES(C_CYCLES)) u_dut3 (
    .clk(clk), .rst(rst), .en(en3),
    .accum_in(accum_in), .accum_out(accum_out), .s1_in(s1_in), .s1_out(s1_out),
    .s2_in(s2_in), .s2_out(s2_out), .s8_in(s8_in), .s8_out(s8_out),
    .s33_in(s33_in), .s33_out(s33_out), .s64_in(s64_in), .s64_out(s64_out),
    .s65_in(s65_in), .s65_out(s65_out), .s129_in(s129_in), .s129_out(s129_out),
    .mismatch_cnt(mc3), .first_err_idx(fi3), .first_err_field(ff3), .done(d3), .pass(p3)
  );

  // Outputs of whichever checker the current run targets.
  logic        sel3;
  logic [15:0] s_mc, s_fi;
  logic [2:0]  s_ff;
  logic        s_done, s_pass;
  always_comb begin
    s_mc   = sel3 ? mc3 : mc1;
    s_fi   = sel3 ? fi3 : fi1;
    s_ff   = sel3 ? ff3 : ff1;
    s_done = sel3 ? d3  : d1;
    s_pass = sel3 ? p3  : p1;
  end

  typedef struct {
    int cnt;
    int idx;
    int field;
    int pass;
    int done_e;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0]  acc_h  [32];
  logic         s1_h   [32];
  logic [1:0]   s2_h   [32];
  logic [7:0]   s8_h   [32];
  logic [32:0]  s33_h  [32];
  logic [63:0]  s64_h  [32];
  logic [64:0]  s65_h  [32];
  logic [128:0] s129_h [32];

  task automatic corrupt(input logic [7:0] m);
    if (m[0]) accum_out[0]  = ~accum_out[0];
    if (m[1]) s1_out        = ~s1_out;
    if (m[2]) s2_out[1]     = ~s2_out[1];
    if (m[3]) s8_out[7]     = ~s8_out[7];
    if (m[4]) s33_out[32]   = ~s33_out[32];
    if (m[5]) s64_out[63]   = ~s64_out[63];
    if (m[6]) s65_out[64]   = ~s65_out[64];
    if (m[7]) s129_out[128] = ~s129_out[128];
  endtask

  // Stub with delay d: at edge e it presents the ideal result for sample e-d.
  task automatic drive(input int e, input int d, input int ek1, input logic [7:0] m1,
                       input int ek2, input logic [7:0] m2);
    int j;
    logic [31:0] sum;
    accum_in = acc_h[e]; s1_in = s1_h[e]; s2_in = s2_h[e]; s8_in = s8_h[e];
    s33_in = s33_h[e]; s64_in = s64_h[e]; s65_in = s65_h[e]; s129_in = s129_h[e];
    j = e - d;
    if (j < 0) begin
      accum_out = '0; s1_out = '0; s2_out = '0; s8_out = '0;
      s33_out = '0; s64_out = '0; s65_out = '0; s129_out = '0;
    end else begin
      sum = '0;
      for (int i = 0; i <= j; i++) sum = sum + acc_h[i];
      accum_out = sum; s1_out = s1_h[j]; s2_out = s2_h[j]; s8_out = s8_h[j];
      s33_out = s33_h[j]; s64_out = s64_h[j]; s65_out = s65_h[j]; s129_out = s129_h[j];
      if (j == ek1) corrupt(m1);
      if (j == ek2) corrupt(m2);
    end
  endtask

  task automatic check_zero(input string name);
    check_val({name, ".cnt0"},  64'(s_mc),   64'd0);
    check_val({name, ".idx0"},  64'(s_fi),   64'd0);
    check_val({name, ".fld0"},  64'(s_ff),   64'd0);
    check_val({name, ".done0"}, 64'(s_done), 64'd0);
    check_val({name, ".pass0"}, 64'(s_pass), 64'd0);
  endtask

  task automatic run(input string name, input int lat, input int d, input bit wrap,
                     input bit hold_en, input int ek1, input logic [7:0] m1,
                     input int ek2, input logic [7:0] m2, input int abort_e,
                     input int x_cnt, input int x_idx, input int x_field, input int x_pass);
    exp_t x, got_x;
    int   done_e;
    bit   popped;
    sel3 = (lat == 3);
    for (int e = 0; e < 32; e++) begin
      acc_h[e]  = wrap ? 32'hFFFF_FFFF : 32'(5 * e);
      s1_h[e]   = 1'($urandom);
      s2_h[e]   = 2'($urandom);
      s8_h[e]   = 8'(e);
      s33_h[e]  = 33'({$urandom, $urandom});
      s64_h[e]  = {$urandom, $urandom};
      s65_h[e]  = 65'({$urandom, $urandom, $urandom});
      s129_h[e] = 129'({$urandom, $urandom, $urandom, $urandom, $urandom});
    end
    if (abort_e < 0) begin
      x = '{cnt: x_cnt, idx: x_idx, field: x_field, pass: x_pass, done_e: lat + C_CYCLES};
      sb.push_back(x);
    end
    en1 = 1'b0; en3 = 1'b0;
    drive(0, 100, -1, 8'h00, -1, 8'h00);
    rst = 1'b1;
    #1;
    check_zero({name, ".reset"});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_e = -1;
    popped = 1'b0;
    for (int e = 0; e <= lat + C_CYCLES + 2; e++) begin
      drive(e, d, ek1, m1, ek2, m2);
      if (sel3) en3 = hold_en || (e == 0);
      else      en1 = hold_en || (e == 0);
      @(posedge clk);
      #1;
      if (e == abort_e) begin
        check_val({name, ".cnt_pre_rst"}, 64'(s_mc), 64'(x_cnt));
        rst = 1'b1;
        #1;
        check_zero({name, ".async_rst"});
        en1 = 1'b0; en3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (s_done && !popped) begin
        done_e = e;
        popped = 1'b1;
        got_x  = sb.pop_front();
        check_val({name, ".done_edge"}, 64'(done_e), 64'(got_x.done_e));
        check_val({name, ".cnt"},       64'(s_mc),   64'(got_x.cnt));
        check_val({name, ".idx"},       64'(s_fi),   64'(got_x.idx));
        check_val({name, ".field"},     64'(s_ff),   64'(got_x.field));
        check_val({name, ".pass"},      64'(s_pass), 64'(got_x.pass));
      end
      @(negedge clk);
    end
    if (!popped) begin
      check_val({name, ".done_seen"}, 64'(s_done), 64'd1);
      got_x = sb.pop_front();
    end else begin
      check_val({name, ".cnt_stable"}, 64'(s_mc), 64'(got_x.cnt));
      check_val({name, ".done_sticky"}, 64'(s_done), 64'd1);
    end
    en1 = 1'b0; en3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en1 = 1'b0; en3 = 1'b0; sel3 = 1'b0;
    //   name        lat d wrap hold ek1 m1     ek2 m2     abort cnt idx fld pass
    run("clean",     1, 1, 0, 1, -1, 8'h00, -1, 8'h00, -1,  0,  0,  0,  1);
    run("single",    1, 1, 0, 0,  3, 8'h40, -1, 8'h00, -1,  1,  3,  6,  0);
    run("simul",     1, 1, 0, 0,  2, 8'h03,  5, 8'h80, -1,  2,  2,  0,  0);
    run("lat3",      3, 3, 0, 0, -1, 8'h00, -1, 8'h00, -1,  0,  0,  0,  1);
    run("lat3_d2",   3, 2, 0, 0, -1, 8'h00, -1, 8'h00, -1, 10,  0,  0,  0);
    run("wrap",      1, 1, 1, 0, -1, 8'h00, -1, 8'h00, -1,  0,  0,  0,  1);
    run("abort",     1, 1, 0, 0,  1, 8'h04, -1, 8'h00,  5,  1,  0,  0,  0);
    run("post_rst",  1, 1, 0, 0, -1, 8'h00, -1, 8'h00, -1,  0,  0,  0,  1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/dpi_prot_checker.md
# dpi_prot_checker

Self-checking scoreboard directly downstream of `dpi_prot_secret` in the protected-DPI regression.
- Samples every value driven into the secret block and delays it through a reference model.
- Compares the model against the secret block's outputs for a fixed number of cycles.
- Reports mismatch count, first-failure location and a pass/done verdict, so the test top decides `$finish` from hardware state rather than a free-running cycle count.

## Interface
- `LATENCY`, 1: cycles from `*_in` sampling to the matching `*_out`; legal 1..4.
- `CHECK_CYCLES`, 10: number of comparisons per run; legal 1..65535.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `en` input 1: start request; sampled only in IDLE.
- `accum_in`, `accum_out` input 32: accumulator stimulus and the secret block's result.
- `s1_in`, `s1_out` input 1: pass-through pair.
- `s2_in`, `s2_out` input 2: pass-through pair.
- `s8_in`, `s8_out` input 8: pass-through pair.
- `s33_in`, `s33_out` input 33: pass-through pair.
- `s64_in`, `s64_out` input 64: pass-through pair.
- `s65_in`, `s65_out` input 65: pass-through pair.
- `s129_in`, `s129_out` input 129: pass-through pair.
- `mismatch_cnt` output 16: count of comparison cycles with at least one failing field; saturates at 0xFFFF.
- `first_err_idx` output 16: comparison index k of the first failure.
- `first_err_field` output 3: field code of the first failure.
- `done` output 1: run complete; sticky until reset.
- `pass` output 1: `done && mismatch_cnt == 0`.

## Operation
- Field codes: 0 accum, 1 s1, 2 s2, 3 s8, 4 s33, 5 s64, 6 s65, 7 s129.
- FSM states: IDLE, FILL, CHECK, DONE.
  - IDLE -> FILL on `en`=1.
  - FILL -> CHECK after LATENCY-1 further cycles. With LATENCY=1, IDLE goes directly to CHECK.
  - CHECK -> DONE after CHECK_CYCLES comparisons.
  - DONE persists until `rst`.
- Sampling: the edge at which `en` is seen in IDLE captures sample 0. Every later edge captures one further sample until DONE.
- Reference model for comparison k (k = 0..CHECK_CYCLES-1), performed at edge LATENCY+k:
  - Expected `accum_out` = sum of `accum_in` samples 0..k, modulo 2^32 (wraps silently).
  - Expected `sN_out` = `sN_in` sample k, full width.
- Per comparison, all 8 fields are checked in parallel. If any field fails:
  - `mismatch_cnt` increments by exactly 1.
  - On the first failing comparison, `first_err_idx` <= k and `first_err_field` <= the lowest failing code.
- `en` changes outside IDLE are ignored.
- Reset values: all outputs 0, state IDLE, delay line and valid bits cleared.

## Timing
- Compare latency: outputs are checked LATENCY edges after their stimulus edge.
- `done` rises registered at edge LATENCY+CHECK_CYCLES, counted from the start edge as 0. `pass` rises in the same cycle.
- `mismatch_cnt`, `first_err_*` update at the same edge as the comparison that causes them. They are stable once `done`=1.
- `rst` asserted mid-FILL/CHECK/DONE:
  - Immediately (asynchronously) clears all state and outputs.
  - The next `en` starts a fresh run; no stale delay-line contents are compared.
- If `en` is held high continuously, it starts exactly one run. A new run needs a reset.
- Saturation: `mismatch_cnt` never wraps; it stays at 0xFFFF.

## Structure
- Package `dpi_prot_chk_pkg` holds:
  - the state enum;
  - the field-code enum (3 bits);
  - width constants W_ACCUM=32, W_S1..W_S129;
  - the concatenated stimulus width (334 = 1+2+8+33+64+65+129, plus 32 for the accumulator).
- Sub-module `dpi_prot_chk_delay`:
  - parameterised DEPTH/WIDTH shift register with a per-stage valid bit;
  - instanced once on the concatenated stimulus vector;
  - tail-valid gates the comparison.
- Running accumulator model and compare/priority logic live in the top.

## Test plan
- **Clean run.** Ideal stub, LATENCY=1; `accum_in` = 0,5,10,...; `s8_in` = cycle count. Expect `done` at edge 11, `mismatch_cnt`=0, `pass`=1.
- **Single-field error.** Stub flips `s65_out`[64] at comparison 3 only. Expect `mismatch_cnt`=1, `first_err_idx`=3, `first_err_field`=6, `pass`=0.
- **Simultaneous errors.**
  - Stub corrupts `accum_out` and `s1_out` at comparison 2. Expect `mismatch_cnt`=1, `first_err_field`=0.
  - Additional `s129_out` error at comparison 5. Expect count 2; first-error fields unchanged.
- **Latency handling.**
  - LATENCY=3 checker with a 3-cycle stub -> `pass`=1, `done` at edge 13.
  - Same checker with a 2-cycle stub and varying stimulus -> `mismatch_cnt`=10, `first_err_idx`=0.
- **Accumulator wrap.** `accum_in` = 0xFFFF_FFFF twice. Expected accum at k=1 is 0xFFFF_FFFE; stub matching it -> `pass`=1.
- **Reset mid-run.**
  - Assert `rst` at comparison 4 of an erroring run. All outputs are 0 within the same cycle.
  - Release `rst`, pulse `en` with the clean stub -> `pass`=1, `mismatch_cnt`=0.
